// File: rtl/serial_borrow_subtractor.sv
// Bit-serial subtractor: computes {borrow, A - B - Bin} one bit per clock, LSB first.
// Optional macro SUB_OVERFLOW_EN adds a signed-overflow flag ovf alongside Out.
module serial_borrow_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   Out,
  output logic             busy
`ifdef SUB_OVERFLOW_EN
  ,output logic            ovf
`endif
);

  localparam int IDX_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               br_q, br_d;
  logic [WIDTH:0]     out_q, out_d;
`ifdef SUB_OVERFLOW_EN
  logic               ovf_q, ovf_d;
`endif

  logic d_bit;
  logic br_next;
  logic last_bit;

  assign d_bit    = a_q[0] ^ b_q[0] ^ br_q;
  assign br_next  = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
  assign last_bit = (idx_q == IDX_W'(WIDTH - 1));

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == BUSY);
  assign out_valid = (state_q == DONE);
  assign Out       = out_q;
`ifdef SUB_OVERFLOW_EN
  assign ovf       = ovf_q;
`endif

  // NOTE: every _d gets its hold value first so no path through this block infers a latch.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    br_d    = br_q;
    out_d   = out_q;
`ifdef SUB_OVERFLOW_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = A;
          b_d     = B;
          br_d    = Bin;
          idx_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // a_q doubles as the difference register: result bits enter at the MSB as operand bits leave.
        a_d   = {d_bit, a_q[WIDTH-1:1]};
        b_d   = {1'b0, b_q[WIDTH-1:1]};
        br_d  = br_next;
        idx_d = idx_q + IDX_W'(1);
        if (last_bit) begin
          out_d   = {br_next, d_bit, a_q[WIDTH-1:1]};
`ifdef SUB_OVERFLOW_EN
          ovf_d   = br_q ^ br_next;
`endif
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the operand shifters are cleared too; they are few flops and this keeps X out of Out paths.
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      br_q    <= 1'b0;
      out_q   <= '0;
`ifdef SUB_OVERFLOW_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      br_q    <= br_d;
      out_q   <= out_d;
`ifdef SUB_OVERFLOW_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

endmodule

// File: tb/tb_serial_borrow_subtractor.sv
// Self-checking bench for serial_borrow_subtractor (WIDTH = 4) against an arithmetic reference model.
module tb_serial_borrow_subtractor;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Bin;
  logic         out_valid;
  logic         out_ready;
  logic [W:0]   Out;
  logic         busy;
`ifdef SUB_OVERFLOW_EN
  logic         ovf;
`endif

  int tests  = 0;
  int failed = 0;

  serial_borrow_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Bin       (Bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Out       (Out),
    .busy      (busy)
`ifdef SUB_OVERFLOW_EN
    ,.ovf      (ovf)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [W:0] ref_out(input int a, input int b, input int bin);
    int d;
    logic [W:0] r;
    d = a - b - bin;
    r[W-1:0] = W'(d);
    r[W]     = (a < b + bin);
    return r;
  endfunction

  function automatic logic ref_ovf(input int a, input int b, input int bin);
    int sa, sb, s;
    sa = (a >= 2**(W-1)) ? a - 2**W : a;
    sb = (b >= 2**(W-1)) ? b - 2**W : b;
    s  = sa - sb - bin;
    return (s < -(2**(W-1))) || (s > 2**(W-1) - 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept one operand set, scramble inputs while busy, and check latency, result and hold-in-IDLE.
  task automatic do_op(input string tag, input int a, input int b, input int bin);
    int n;
    logic [W:0] exp;
    exp       = ref_out(a, b, bin);
    A         = W'(a);
    B         = W'(b);
    Bin       = 1'(bin);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check({tag, "_nready"}, 32'(in_ready), 32'd0);
    n = 0;
    while (!out_valid && n < 20) begin
      A         = W'($urandom);
      B         = W'($urandom);
      Bin       = 1'($urandom);
      out_ready = 1'($urandom);
      step();
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'(W));
    check({tag, "_out"}, 32'(Out), 32'(exp));
`ifdef SUB_OVERFLOW_EN
    check({tag, "_ovf"}, 32'(ovf), 32'(ref_ovf(a, b, bin)));
`endif
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_idle_hold"}, 32'(Out), 32'(exp));
  endtask

  initial begin
    int seen;
    int cyc;
    int last_acc;
    int results;
    logic pre_ready;
    logic [W:0] q[$];
    logic [W:0] exp;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0; Bin = 1'b0;
    step();
    step();
    rst = 1'b0;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out", 32'(Out), 32'd0);

    do_op("d3m2", 3, 2, 0);
    check("d3m2_const", 32'(Out), 32'h01);
    do_op("d0m0b", 0, 0, 1);
    check("d0m0b_const", 32'(Out), 32'h1F);
    do_op("d1m5b", 1, 5, 1);
    check("d1m5b_const", 32'(Out), 32'h1B);
    do_op("d2m3b", 2, 3, 1);
    check("d2m3b_const", 32'(Out), 32'h1E);

    for (int i = 0; i < 12; i++)
      do_op("rnd", int'($urandom_range(0, 2**W - 1)), int'($urandom_range(0, 2**W - 1)),
            int'($urandom_range(0, 1)));

    // Reset two edges after accept: the operation must vanish.
    A = 4'd7; B = 4'd1; Bin = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_out", 32'(Out), 32'd0);
    check("midrst_ready", 32'(in_ready), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) seen++;
      step();
    end
    check("midrst_no_valid", 32'(seen), 32'd0);

    // DONE held with out_ready low while new operands are offered.
    A = 4'd3; B = 4'd2; Bin = 1'b1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < W - 1; i++) step();
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      A = W'($urandom);
      B = W'($urandom);
      step();
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_out", 32'(Out), 32'h00);
      check("hold_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("hold_release_ready", 32'(in_ready), 32'd1);
    check("hold_release_valid", 32'(out_valid), 32'd0);

`ifdef SUB_OVERFLOW_EN
    do_op("ovf8m1", 8, 1, 0);
    check("ovf8m1_const", 32'({ovf, Out}), 32'h27);
    do_op("ovf4m2", 4, 2, 0);
    check("ovf4m2_const", 32'({ovf, Out}), 32'h02);
`endif

    // Reset wins over a simultaneous in_valid.
    rst = 1'b1; in_valid = 1'b1;
    step();
    rst = 1'b0; in_valid = 1'b0;
    check("rst_prio_busy", 32'(busy), 32'd0);
    check("rst_prio_ready", 32'(in_ready), 32'd1);

    // Back-to-back streaming with in_valid and out_ready held high.
    in_valid = 1'b1; out_ready = 1'b1;
    cyc = 0; last_acc = -1; results = 0;
    while (results < 4 && cyc < 200) begin
      A   = W'($urandom);
      B   = W'($urandom);
      Bin = 1'($urandom);
      pre_ready = in_ready;
      exp = ref_out(int'(A), int'(B), int'(Bin));
      step();
      cyc++;
      if (pre_ready) begin
        q.push_back(exp);
        if (last_acc >= 0) check("b2b_interval", 32'(cyc - last_acc), 32'(W + 2));
        last_acc = cyc;
      end
      if (out_valid) begin
        if (q.size() > 0) check("b2b_out", 32'(Out), 32'(q.pop_front()));
        else check("b2b_spurious", 32'(out_valid), 32'd0);
        results++;
      end
    end
    check("b2b_count", 32'(results), 32'd4);
    in_valid = 1'b0;
    step();
    out_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
